i2c_reg_sequencer: RTL and testbench

Parametrised table-driven I2C register initialiser, the next generation of the fixed HDMI transmitter configurator. It walks an external synchronous ROM of write/delay/end entries and drives the existing `i2c` write-master handshake, which is instantiated alongside it. Compared with the fixed configurator, it adds:
- generic slave address and register-address width;
- bounded retry with error reporting instead of infinite retry;
- a restart request for reconfiguration on mode change;
- an optional delay opcode.

---
 rtl/i2c_seq_pkg.sv | 26 ++
 rtl/i2c_seq_timer.sv | 33 +++
 rtl/i2c_reg_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the table-driven I2C register sequencer.
//   OP_*          : opcode encodings of the top two bits of a table entry
//   seq_state_t   : sequencer FSM states
//   entry_w()     : width of one table entry {opcode, reg, data}
package i2c_seq_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END   = 2'b11;  // 2'b10 is reserved and behaves as END

    typedef enum logic [2:0] {
        StFetch,
        StLatch,
        StDecode,
        StStart,
        StXfer,
        StGap,
        StDelay,
        StDone
    } seq_state_t;

    function automatic int unsigned entry_w(input int unsigned reg_aw);
        return 2 + reg_aw + 8;
    endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter with a done flag; shared by the retry gap and the delay opcode.
//   clk   : clock
//   rst   : synchronous active-high reset
//   load  : load value into the counter (takes priority over counting)
//   value : load value
//   done  : counter is at zero
module i2c_seq_timer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Table-driven I2C register initialiser. Walks a synchronous ROM of WRITE/DELAY/END entries
// and drives the write-master start/end handshake, with bounded retry on NACK.
// Build option: define I2C_SEQ_DELAY_EN to honour the DELAY opcode; otherwise DELAY is a no-op.
// Ports:
//   iCLK, iRST        : clock, synchronous active-high reset
//   iRESTART          : one-cycle pulse, re-run the table from index 0
//   oTBL_ADDR         : ROM address; iTBL_DATA valid one cycle later
//   oI2C_START        : level start request to the I2C master
//   oI2C_DATA         : {SLAVE_ADDR, reg, data}
//   iI2C_END/iI2C_ACK : master idle flag / NACK flag sampled when END rises
//   oBUSY, oDONE      : sequencing / END reached
//   oERR, oERR_INDEX  : sticky abandon flag, index of first abandoned entry
//   oNACK_CNT         : saturating NACK count since last (re)start
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR = 8'h72,
    parameter int unsigned REG_AW     = 8,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned RETRY_GAP  = 1000,
    parameter int unsigned DELAY_UNIT = 50_000
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iRESTART,
    output logic [IDX_W-1:0]            oTBL_ADDR,
    input  logic [entry_w(REG_AW)-1:0]  iTBL_DATA,
    output logic                        oI2C_START,
    output logic [16+REG_AW-1:0]        oI2C_DATA,
    input  logic                        iI2C_END,
    input  logic                        iI2C_ACK,
    output logic                        oBUSY,
    output logic                        oDONE,
    output logic                        oERR,
    output logic [IDX_W-1:0]            oERR_INDEX,
    output logic [7:0]                  oNACK_CNT
);

    localparam int unsigned EW    = entry_w(REG_AW);
    localparam int unsigned DW    = 16 + REG_AW;
    localparam int unsigned GAP_W = $clog2(RETRY_GAP + 1);
    localparam int unsigned RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef I2C_SEQ_DELAY_EN
    localparam int unsigned DLY_W = $clog2(255 * DELAY_UNIT + 1);
    localparam int unsigned TW    = (DLY_W > GAP_W) ? DLY_W : GAP_W;
`else
    localparam int unsigned TW    = GAP_W;
`endif

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [EW-1:0]    entry_q, entry_d;
    logic [DW-1:0]    data_q, data_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic [7:0]       nack_q, nack_d;
    logic             pend_q, pend_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_value;
    logic             tmr_done;

    logic             last_idx;
    logic [IDX_W-1:0] idx_next;
    seq_state_t       adv_state;
    logic             restart_now;
    logic [1:0]       opcode;

    i2c_seq_timer #(
        .W(TW)
    ) u_timer (
        .clk  (iCLK),
        .rst  (iRST),
        .load (tmr_load),
        .value(tmr_value),
        .done (tmr_done)
    );

    assign opcode = entry_q[EW-1 -: 2];

    // Advancing past the last index ends the table instead of wrapping to 0.
    assign last_idx  = &idx_q;
    assign idx_next  = last_idx ? idx_q : idx_q + 1'b1;
    assign adv_state = last_idx ? StDone : StFetch;

    // A bus transaction is never aborted: restart in START/XFER waits for END to rise.
    assign restart_now = (iRESTART && !(state_q inside {StStart, StXfer})) ||
                         (state_q == StXfer && iI2C_END && (pend_q || iRESTART));

`ifdef I2C_SEQ_DELAY_EN
    logic [TW-1:0] dly_cycles;
    assign dly_cycles = TW'(entry_q[7:0]) * TW'(DELAY_UNIT);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        entry_d   = entry_q;
        data_d    = data_q;
        retry_d   = retry_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        nack_d    = nack_q;
        pend_d    = pend_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            StFetch: state_d = StLatch;
            StLatch: begin
                entry_d = iTBL_DATA;
                state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OP_WRITE: begin
                        data_d  = {SLAVE_ADDR, entry_q[EW-3:0]};
                        state_d = StStart;
                    end
                    OP_DELAY: begin
`ifdef I2C_SEQ_DELAY_EN
                        // DECODE counts as the first delay cycle, so FETCH follows
                        // exactly dly_cycles after DECODE.
                        if (dly_cycles <= TW'(1)) begin
                            idx_d   = idx_next;
                            state_d = adv_state;
                        end else begin
                            tmr_load  = 1'b1;
                            tmr_value = dly_cycles - TW'(2);
                            state_d   = StDelay;
                        end
`else
                        idx_d   = idx_next;
                        state_d = adv_state;
`endif
                    end
                    default: state_d = StDone;
                endcase
            end
            StStart: begin
                if (iRESTART) pend_d = 1'b1;
                if (!iI2C_END) state_d = StXfer;
            end
            StXfer: begin
                if (iRESTART) pend_d = 1'b1;
                if (iI2C_END) begin
                    if (!iI2C_ACK) begin
                        retry_d = '0;
                        idx_d   = idx_next;
                        state_d = adv_state;
                    end else begin
                        if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d   = retry_q + 1'b1;
                            tmr_load  = 1'b1;
                            tmr_value = TW'(RETRY_GAP - 1);
                            state_d   = StGap;
                        end else begin
                            err_d   = 1'b1;
                            if (!err_q) err_idx_d = idx_q;
                            retry_d = '0;
                            idx_d   = idx_next;
                            state_d = adv_state;
                        end
                    end
                end
            end
            StGap: begin
                if (tmr_done) state_d = StStart;
            end
`ifdef I2C_SEQ_DELAY_EN
            StDelay: begin
                if (tmr_done) begin
                    idx_d   = idx_next;
                    state_d = adv_state;
                end
            end
`endif
            StDone: state_d = StDone;
            default: state_d = StFetch;
        endcase

        // Restart overrides whatever the state logic decided, including a discarded ACK.
        if (restart_now) begin
            state_d   = StFetch;
            idx_d     = '0;
            retry_d   = '0;
            err_d     = 1'b0;
            err_idx_d = '0;
            nack_d    = '0;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= StFetch;
            idx_q     <= '0;
            entry_q   <= '0;
            data_q    <= '0;
            retry_q   <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            nack_q    <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            entry_q   <= entry_d;
            data_q    <= data_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            nack_q    <= nack_d;
            pend_q    <= pend_d;
        end
    end

    assign oTBL_ADDR  = idx_q;
    assign oI2C_START = (state_q == StStart);
    assign oI2C_DATA  = data_q;
    assign oBUSY      = (state_q != StDone);
    assign oDONE      = (state_q == StDone);
    assign oERR       = err_q;
    assign oERR_INDEX = err_idx_q;
    assign oNACK_CNT  = nack_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench: tests push expected I2C words, monitors pop them on each START rise.
// Main instance: REG_AW=8, IDX_W=4. Second instance: REG_AW=16, IDX_W=8, table with no END.
module tb_i2c_reg_sequencer;

    localparam int RETRY_GAP = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- main instance ----------------
    logic        rst = 1'b1, restart = 1'b0;
    logic [3:0]  tbl_addr;
    logic [17:0] tbl_data;
    logic        i2c_start;
    logic [23:0] i2c_data;
    logic        m_end = 1'b1, m_ack = 1'b0;
    logic        busy, done, err;
    logic [3:0]  err_idx;
    logic [7:0]  nack_cnt;
    logic [17:0] rom [16];

    i2c_reg_sequencer #(
        .SLAVE_ADDR(8'h72), .REG_AW(8), .IDX_W(4), .MAX_RETRY(3),
        .RETRY_GAP(RETRY_GAP), .DELAY_UNIT(10)
    ) dut (
        .iCLK(clk), .iRST(rst), .iRESTART(restart), .oTBL_ADDR(tbl_addr),
        .iTBL_DATA(tbl_data), .oI2C_START(i2c_start), .oI2C_DATA(i2c_data),
        .iI2C_END(m_end), .iI2C_ACK(m_ack), .oBUSY(busy), .oDONE(done), .oERR(err),
        .oERR_INDEX(err_idx), .oNACK_CNT(nack_cnt)
    );

    always @(posedge clk) tbl_data <= rom[tbl_addr];

    logic [23:0] exp_q[$];
    bit          plan_q[$];
    int          attempts = 0;
    int          nack_cyc = 0;
    bit          last_nack = 1'b0;
    bit          chk_gap = 1'b0;

    // I2C master model: answers each start with a 4-cycle transfer, NACK per plan_q.
    initial begin
        forever begin
            @(negedge clk);
            if (i2c_start && m_end) begin
                m_end = 1'b0;
                attempts++;
                repeat (4) @(negedge clk);
                m_ack = (plan_q.size() != 0) ? plan_q.pop_front() : 1'b0;
                last_nack = m_ack;
                nack_cyc = cyc;
                m_end = 1'b1;
                @(negedge clk);
                m_ack = 1'b0;
            end
        end
    end

    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_start && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got data %0h expected no transaction", i2c_data);
                end else begin
                    check("i2c_data", 64'(i2c_data), 64'(exp_q.pop_front()));
                end
                if (chk_gap && last_nack)
                    check("retry_gap_min", 64'((cyc - nack_cyc - 1) >= RETRY_GAP), 64'd1);
            end
            prev = i2c_start;
        end
    end

    // ---------------- 16-bit register instance ----------------
    logic        rst16 = 1'b1, restart16 = 1'b0;
    logic [7:0]  addr16;
    logic [33:0] tbl16;
    logic        start16;
    logic [31:0] data16;
    logic        end16 = 1'b1, ack16 = 1'b0;
    logic        busy16, done16, err16;
    logic [7:0]  erridx16, nack16;
    logic [31:0] exp16_q[$];

    i2c_reg_sequencer #(
        .SLAVE_ADDR(8'h72), .REG_AW(16), .IDX_W(8), .MAX_RETRY(3),
        .RETRY_GAP(RETRY_GAP), .DELAY_UNIT(10)
    ) dut16 (
        .iCLK(clk), .iRST(rst16), .iRESTART(restart16), .oTBL_ADDR(addr16),
        .iTBL_DATA(tbl16), .oI2C_START(start16), .oI2C_DATA(data16),
        .iI2C_END(end16), .iI2C_ACK(ack16), .oBUSY(busy16), .oDONE(done16), .oERR(err16),
        .oERR_INDEX(erridx16), .oNACK_CNT(nack16)
    );

    // Every entry is a WRITE of reg {A5, idx} with data idx^5A; no END anywhere.
    always @(posedge clk) tbl16 <= {2'b00, 8'hA5, addr16, addr16 ^ 8'h5A};

    initial begin
        forever begin
            @(negedge clk);
            if (start16 && end16) begin
                end16 = 1'b0;
                repeat (3) @(negedge clk);
                end16 = 1'b1;
            end
        end
    end

    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (start16 && !prev) begin
                if (exp16_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start16: got data %0h expected no transaction", data16);
                end else begin
                    check("i2c_data16", 64'(data16), 64'(exp16_q.pop_front()));
                end
            end
            prev = start16;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [17:0] wr(input logic [7:0] r, input logic [7:0] d);
        return {2'b00, r, d};
    endfunction

    task automatic load_end_all();
        for (int i = 0; i < 16; i++) rom[i] = 18'h30000;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int a0, n, viol, cnt;

        // A: two writes then END, always ACK
        load_end_all();
        rom[0] = wr(8'h98, 8'h03);
        rom[1] = wr(8'hD6, 8'hC0);
        exp_q.push_back(24'h729803);
        exp_q.push_back(24'h72D6C0);
        repeat (3) @(negedge clk);
        check("rst_start", 64'(i2c_start), 64'd0);
        check("rst_addr", 64'(tbl_addr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_idx", 64'(err_idx), 64'd0);
        check("rst_nack", 64'(nack_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst16_busy", 64'(busy16), 64'd1);
        check("rst16_data", 64'(data16), 64'd0);
        rst = 1'b0;
        wait_done("a_done", 200);
        check("a_busy", 64'(busy), 64'd0);
        check("a_err", 64'(err), 64'd0);
        check("a_addr", 64'(tbl_addr), 64'd2);
        check("a_queue", 64'(exp_q.size()), 64'd0);
        check("a_attempts", 64'(attempts), 64'd2);

        // B: entry 1 NACKs twice then ACKs
        load_end_all();
        rom[0] = wr(8'h11, 8'h11);
        rom[1] = wr(8'h22, 8'h22);
        rom[2] = wr(8'h33, 8'h33);
        exp_q.push_back(24'h721111);
        repeat (3) exp_q.push_back(24'h722222);
        exp_q.push_back(24'h723333);
        plan_q = '{1'b0, 1'b1, 1'b1, 1'b0};
        a0 = attempts;
        chk_gap = 1'b1;
        pulse_restart();
        wait_done("b_done", 400);
        chk_gap = 1'b0;
        check("b_nack", 64'(nack_cnt), 64'd2);
        check("b_err", 64'(err), 64'd0);
        check("b_attempts", 64'(attempts - a0), 64'd5);
        check("b_queue", 64'(exp_q.size()), 64'd0);

        // C: entry 2 always NACKs -> abandoned after 4 attempts
        load_end_all();
        rom[0] = wr(8'hA0, 8'h00);
        rom[1] = wr(8'hA1, 8'h11);
        rom[2] = wr(8'hA2, 8'h22);
        exp_q.push_back(24'h72A000);
        exp_q.push_back(24'h72A111);
        repeat (4) exp_q.push_back(24'h72A222);
        plan_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pulse_restart();
        wait_done("c_done", 600);
        check("c_err", 64'(err), 64'd1);
        check("c_err_idx", 64'(err_idx), 64'd2);
        check("c_nack", 64'(nack_cnt), 64'd4);
        check("c_queue", 64'(exp_q.size()), 64'd0);

        // D: restart while entry 3 is on the bus
        load_end_all();
        rom[0] = wr(8'hB0, 8'h00);
        rom[1] = wr(8'hB1, 8'h01);
        rom[2] = wr(8'hB2, 8'h02);
        rom[3] = wr(8'hB3, 8'h03);
        exp_q = '{24'h72B000, 24'h72B000, 24'h72B101, 24'h72B202, 24'h72B303,
                  24'h72B000, 24'h72B101, 24'h72B202, 24'h72B303};
        plan_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        a0 = attempts;
        pulse_restart();
        n = 0;
        while (!(attempts == a0 + 5 && !m_end) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("d_reach_xfer", 64'(attempts - a0), 64'd5);
        check("d_err_cleared", 64'(err), 64'd0);
        check("d_nack_before", 64'(nack_cnt), 64'd1);
        pulse_restart();
        viol = 0;
        n = 0;
        while (!m_end && n < 50) begin
            @(negedge clk);
            if (i2c_start) viol++;
            n++;
        end
        check("d_no_restart_start", 64'(viol), 64'd0);
        check("d_end_rose", 64'(m_end), 64'd1);
        @(negedge clk);
        check("d_addr0", 64'(tbl_addr), 64'd0);
        check("d_nack_clr", 64'(nack_cnt), 64'd0);
        wait_done("d_done", 400);
        check("d_nack_final", 64'(nack_cnt), 64'd0);
        check("d_queue", 64'(exp_q.size()), 64'd0);

        // E: DELAY 2 x DELAY_UNIT(10), then a zero-count DELAY
        load_end_all();
        rom[0] = wr(8'hC0, 8'h01);
        rom[1] = {2'b01, 8'h00, 8'h02};
        rom[2] = wr(8'hC1, 8'h02);
        rom[3] = {2'b01, 8'h00, 8'h00};
        exp_q.push_back(24'h72C001);
        exp_q.push_back(24'h72C102);
        pulse_restart();
        n = 0;
        while (tbl_addr != 4'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (tbl_addr == 4'd1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
`ifdef I2C_SEQ_DELAY_EN
        check("e_delay_cycles", 64'(cnt), 64'd22);
`else
        check("e_delay_cycles", 64'(cnt), 64'd3);
`endif
        n = 0;
        while (tbl_addr != 4'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (tbl_addr == 4'd3 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("e_zero_delay_cycles", 64'(cnt), 64'd3);
        wait_done("e_done", 200);
        check("e_queue", 64'(exp_q.size()), 64'd0);

        // F: 16-bit registers, 256 entries, no END -> DONE after index 255
        for (int i = 0; i < 256; i++)
            exp16_q.push_back({8'h72, 8'hA5, 8'(i), 8'(i) ^ 8'h5A});
        rst16 = 1'b0;
        n = 0;
        while (!done16 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("f_done", 64'(done16), 64'd1);
        check("f_busy", 64'(busy16), 64'd0);
        check("f_addr", 64'(addr16), 64'd255);
        check("f_queue", 64'(exp16_q.size()), 64'd0);
        check("f_err", 64'(err16), 64'd0);
        check("f_err_idx", 64'(erridx16), 64'd0);
        check("f_nack", 64'(nack16), 64'd0);
        repeat (20) @(negedge clk);
        check("f_hold_done", 64'(done16), 64'd1);
        check("f_hold_addr", 64'(addr16), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
